// File: rtl/lcd_spi_streamer.sv
// lcd_spi_streamer: valid/ready byte stream to MSB-first SPI mode 0 with CS-framed fixed-length bursts.
// Define LCD_SPI_STREAM_FLOWCTRL_EN to gate o_ready with the downstream FIFO almost-full flag.
module lcd_spi_streamer #(
    parameter int CLK_DIV         = 4,
    parameter int BYTES_PER_BURST = 120,
    parameter int CS_SETUP        = 2,
    parameter int CS_GAP          = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_wfull_almost,
    output logic       o_spi_mosi,
    output logic       o_spi_clk,
    output logic       o_spi_cs_n,
    output logic       o_busy,
    output logic       o_burst_done
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, TEARDOWN, GAP} state_t;
    localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);
    localparam logic [15:0] BURST_LEN = 16'(BYTES_PER_BURST);
    state_t      state;
    logic [15:0] cnt;
    logic [15:0] byte_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  sr;
    logic        flow_ok;
    logic        accept;
`ifdef LCD_SPI_STREAM_FLOWCTRL_EN
    assign flow_ok = !i_wfull_almost;
`else
    logic unused_wfull;
    assign unused_wfull = i_wfull_almost;
    assign flow_ok = 1'b1;
`endif
    assign o_ready = !i_reset && flow_ok && (state == IDLE || state == NEXT);
    assign accept  = i_valid && o_ready;
    assign o_busy  = state != IDLE;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            byte_cnt     <= '0;
            bit_cnt      <= '0;
            sr           <= '0;
            o_spi_mosi   <= 1'b0;
            o_spi_clk    <= 1'b0;
            o_spi_cs_n   <= 1'b1;
            o_burst_done <= 1'b0;
        end else begin
            o_burst_done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    sr         <= i_data[6:0];
                    o_spi_mosi <= i_data[7];
                    o_spi_cs_n <= 1'b0;
                    cnt        <= '0;
                    state      <= SETUP;
                end
                SETUP: begin
                    cnt     <= (cnt == SETUP_END) ? '0 : cnt + 16'd1;
                    bit_cnt <= '0;
                    state   <= (cnt == SETUP_END) ? SHIFT : SETUP;
                end
                SHIFT: begin
                    cnt <= (cnt == DIV_END) ? '0 : cnt + 16'd1;
                    if (cnt == DIV_END) begin
                        o_spi_clk <= !o_spi_clk;
                        // end of a high half: falling edge, so present the next bit
                        if (o_spi_clk) begin
                            o_spi_mosi <= sr[6];
                            sr         <= {sr[5:0], 1'b0};
                            bit_cnt    <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 16'd1;
                                state    <= (byte_cnt + 16'd1 == BURST_LEN) ? TEARDOWN : NEXT;
                            end
                        end
                    end
                end
                NEXT: if (accept) begin
                    sr         <= i_data[6:0];
                    o_spi_mosi <= i_data[7];
                    bit_cnt    <= '0;
                    cnt        <= '0;
                    state      <= SHIFT;
                end
                TEARDOWN: begin
                    cnt <= (cnt == DIV_END) ? '0 : cnt + 16'd1;
                    if (cnt == DIV_END) begin
                        o_spi_cs_n   <= 1'b1;
                        o_burst_done <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= GAP;
                    end
                end
                GAP: begin
                    cnt   <= (cnt == GAP_END) ? '0 : cnt + 16'd1;
                    state <= (cnt == GAP_END) ? IDLE : GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_spi_streamer.sv
// tb_lcd_spi_streamer: scoreboard bench; stimulus queues expected bytes, an SPI monitor pops and compares.
module tb_lcd_spi_streamer;
    logic       i_clk = 0, i_reset = 1, i_valid = 0, i_wfull_almost = 0;
    logic [7:0] i_data = 0;
    logic       o_ready, o_spi_mosi, o_spi_clk, o_spi_cs_n, o_busy, o_burst_done;
    int         checks = 0, failures = 0;
    logic [7:0] q[$];
    int         rises = 0, dones = 0, bytes_rx = 0, bit_n = 0, cs_len = 0, last_len = 0;
    logic [7:0] sh = 0;
    logic       prev_sclk = 0, prev_cs = 1;
    int         w, r0, r1, d0, bad, t, base;

    lcd_spi_streamer #(.CLK_DIV(2), .BYTES_PER_BURST(3), .CS_SETUP(2), .CS_GAP(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_wfull_almost(i_wfull_almost), .o_spi_mosi(o_spi_mosi), .o_spi_clk(o_spi_clk),
        .o_spi_cs_n(o_spi_cs_n), .o_busy(o_busy), .o_burst_done(o_burst_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    // SPI receiver: samples MOSI on each SCLK rising edge, tracks CS windows and done pulses
    always @(negedge i_clk) begin
        if (i_reset) begin
            bit_n = 0; prev_sclk = 0; prev_cs = 1; cs_len = 0;
        end else begin
            if (o_spi_clk && !prev_sclk) begin
                rises++;
                sh = {sh[6:0], o_spi_mosi};
                bit_n++;
                if (bit_n == 8) begin
                    bit_n = 0;
                    bytes_rx++;
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rx_unexpected: got 0x%0h, want none", sh);
                    end else check("rx_byte", sh, q.pop_front());
                end
            end
            if (!o_spi_cs_n) cs_len++;
            else if (!prev_cs) begin last_len = cs_len; cs_len = 0; end
            if (o_burst_done) dones++;
            prev_sclk = o_spi_clk;
            prev_cs = o_spi_cs_n;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit push, output int waited);
        i_data = b; i_valid = 1; waited = 0;
        while (!o_ready && waited < 200) begin tick(); waited++; end
        check("accept_in_time", o_ready, 1);
        if (!o_ready) begin i_valid = 0; return; end
        @(posedge i_clk);
        if (push) q.push_back(b);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_burst_done && n < 400) begin tick(); n++; end
        check("burst_done_seen", o_burst_done, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(o_ready && !o_busy) && n < 100) begin tick(); n++; end
        check("idle_reached", o_ready && !o_busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        tick();
        check("rst_cs_n", o_spi_cs_n, 1);
        check("rst_sclk", o_spi_clk, 0);
        check("rst_mosi", o_spi_mosi, 0);
        check("rst_ready", o_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_burst_done, 0);
        i_reset = 0;
        tick();
        check("idle_ready", o_ready, 1);

        // back-to-back burst
        r0 = rises; d0 = dones;
        send(8'h81, 1, w); send(8'h7E, 1, w); send(8'hFF, 1, w);
        i_valid = 0;
        wait_done();
        bad = 0;
        for (int i = 0; i < 4; i++) begin bad += int'(o_ready); tick(); end
        check("gap_ready_low", bad, 0);
        check("ready_after_gap", o_ready, 1);
        check("b2b_cs_window", last_len, 102);
        check("b2b_rises", rises - r0, 24);
        check("b2b_done_pulses", dones - d0, 1);

        // stall in NEXT
        d0 = dones;
        send(8'hA5, 1, w);
        i_valid = 0;
        t = 0;
        while (!o_ready && t < 100) begin tick(); t++; end
        check("stall_next_ready", o_ready, 1);
        r1 = rises; bad = 0;
        repeat (50) begin tick(); bad += int'(o_spi_cs_n); end
        check("stall_rises", rises - r1, 0);
        check("stall_cs_low", bad, 0);
        send(8'h5A, 1, w); send(8'h3C, 1, w);
        i_valid = 0;
        wait_done();
        wait_idle();
        check("stall_done_pulses", dones - d0, 1);

        // flow control raised during byte 2
        base = bytes_rx;
        send(8'h11, 1, w); send(8'h22, 1, w);
        i_valid = 0;
        repeat (10) tick();
        i_wfull_almost = 1;
`ifdef LCD_SPI_STREAM_FLOWCTRL_EN
        t = 0;
        while (bytes_rx < base + 2 && t < 100) begin tick(); t++; end
        check("flow_byte2_done", bytes_rx - base, 2);
        r1 = rises; bad = 0;
        repeat (20) begin tick(); bad += int'(o_ready); end
        check("flow_blocked_ready", bad, 0);
        check("flow_blocked_rises", rises - r1, 0);
        check("flow_blocked_cs", o_spi_cs_n, 0);
        i_wfull_almost = 0;
        #1;
        check("flow_unblocked_ready", o_ready, 1);
        send(8'h33, 1, w);
`else
        send(8'h33, 1, w);
        check("noflow_prompt_accept", int'(w < 30), 1);
        i_wfull_almost = 0;
`endif
        i_valid = 0;
        wait_done();
        wait_idle();

        // reset mid-SHIFT abandons the partial byte
        send(8'hC3, 0, w);
        i_valid = 0;
        repeat (5) tick();
        check("pre_rst_busy", o_busy, 1);
        check("pre_rst_sclk", o_spi_clk, 1);
        d0 = dones;
        i_reset = 1;
        #1;
        check("midrst_cs_n", o_spi_cs_n, 1);
        check("midrst_sclk", o_spi_clk, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_ready", o_ready, 0);
        tick(); tick();
        i_reset = 0;
        tick();
        check("midrst_no_done", dones - d0, 0);
        check("post_rst_ready", o_ready, 1);
        send(8'h12, 1, w); send(8'h34, 1, w); send(8'h56, 1, w);
        i_valid = 0;
        wait_done();
        repeat (5) tick();
        check("post_rst_cs_window", last_len, 102);
        check("post_rst_done_pulses", dones - d0, 1);
        wait_idle();

        // six bytes across two bursts
        d0 = dones;
        for (int i = 0; i < 6; i++) send(8'(i), 1, w);
        i_valid = 0;
        wait_done();
        wait_idle();
        check("two_burst_dones", dones - d0, 2);

        repeat (3) tick();
        check("queue_drained", q.size(), 0);
        check("no_partial_bits", bit_n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
